// File: rtl/addsub_input_sync_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the add/sub input synchroniser.
//   state_t : pairing FSM states (pair both operands / discard a remainder)
//   A_SLOT  : item slot of operand A inside the combined output word
//   B_SLOT  : item slot of operand B inside the combined output word
// -----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      S_PAIR    = 2'd0,  // both operands consumed together
      S_DRAIN_A = 2'd1,  // B packet ended early, discard rest of A packet
      S_DRAIN_B = 2'd2   // A packet ended early, discard rest of B packet
   } state_t;

   // Output word is {B, A}: A in the low item slot, B in the high item slot.
   localparam int A_SLOT = 0;
   localparam int B_SLOT = 1;

endpackage

// File: rtl/addsub_input_sync.sv
// -----------------------------------------------------------------------------
// addsub_input_sync
// Pairs two AXI-Stream operand streams (A, B) into one combined beat stream
// for the add/sub core. When one operand packet ends before the other, the
// paired packet is terminated and the rest of the longer packet is discarded.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous flush of FSM, output register and counter
//   in_a_*              operand A stream (tdata/tlast/tvalid in, tready out)
//   in_b_*              operand B stream (tdata/tlast/tvalid in, tready out)
//   out_*               paired stream, tdata = {B, A}, single register stage
//   mismatch_pulse      one-cycle pulse for each packet length mismatch
//   mismatch_count      saturating count of mismatches
//   dbg_state           current FSM state (addsub_pkg::state_t encoding)
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// A source never lowers tvalid or changes tdata/tlast before its transfer;
// out_tdata/out_tlast are held while out_tvalid=1 && out_tready=0.
// -----------------------------------------------------------------------------
module addsub_input_sync
   import addsub_pkg::*;
#(
   parameter int ITEM_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [ITEM_W-1:0]     in_a_tdata,
   input  logic                  in_a_tlast,
   input  logic                  in_a_tvalid,
   output logic                  in_a_tready,
   input  logic [ITEM_W-1:0]     in_b_tdata,
   input  logic                  in_b_tlast,
   input  logic                  in_b_tvalid,
   output logic                  in_b_tready,
   output logic [2*ITEM_W-1:0]   out_tdata,
   output logic                  out_tlast,
   output logic                  out_tvalid,
   input  logic                  out_tready,
   output logic                  mismatch_pulse,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic [1:0]            dbg_state
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2*ITEM_W-1:0]   r_out_tdata;
   logic                  r_out_tlast;
   logic                  r_out_tvalid;
   logic                  r_mismatch_pulse;
   logic [CNT_W-1:0]      r_mismatch_count;

   logic                  w_out_free;
   logic                  w_pair;
   logic                  w_mismatch;
   logic                  w_a_ready;
   logic                  w_b_ready;

   // Output register can accept a new beat when empty or emptying this cycle.
   assign w_out_free = !r_out_tvalid || out_tready;

   always_comb begin
      w_state_nxt = r_state;
      w_pair      = 1'b0;
      w_mismatch  = 1'b0;
      w_a_ready   = 1'b0;
      w_b_ready   = 1'b0;
      if (clear) begin
         w_state_nxt = S_PAIR;
      end else begin
         case (r_state)
            S_PAIR: begin
               // Both operands move together or not at all.
               w_pair    = w_out_free && in_a_tvalid && in_b_tvalid;
               w_a_ready = w_pair;
               w_b_ready = w_pair;
               if (w_pair) begin
                  if (in_a_tlast && !in_b_tlast) begin
                     w_state_nxt = S_DRAIN_B;
                     w_mismatch  = 1'b1;
                  end else if (in_b_tlast && !in_a_tlast) begin
                     w_state_nxt = S_DRAIN_A;
                     w_mismatch  = 1'b1;
                  end
               end
            end
            S_DRAIN_B: begin
               w_b_ready = 1'b1;
               if (in_b_tvalid && in_b_tlast) begin
                  w_state_nxt = S_PAIR;
               end
            end
            S_DRAIN_A: begin
               w_a_ready = 1'b1;
               if (in_a_tvalid && in_a_tlast) begin
                  w_state_nxt = S_PAIR;
               end
            end
            default: begin
               w_state_nxt = S_PAIR;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_PAIR;
         r_out_tdata      <= '0;
         r_out_tlast      <= 1'b0;
         r_out_tvalid     <= 1'b0;
         r_mismatch_pulse <= 1'b0;
         r_mismatch_count <= '0;
      end else if (clear) begin
         r_state          <= S_PAIR;
         r_out_tvalid     <= 1'b0;
         r_mismatch_pulse <= 1'b0;
         r_mismatch_count <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_mismatch_pulse <= w_mismatch;
         if (w_pair) begin
            r_out_tdata[A_SLOT*ITEM_W +: ITEM_W] <= in_a_tdata;
            r_out_tdata[B_SLOT*ITEM_W +: ITEM_W] <= in_b_tdata;
            r_out_tlast  <= in_a_tlast || in_b_tlast;
            r_out_tvalid <= 1'b1;
         end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
         end
         // Pulse still fires at saturation; only the count stops.
         if (w_mismatch && (r_mismatch_count != {CNT_W{1'b1}})) begin
            r_mismatch_count <= r_mismatch_count + 1'b1;
         end
      end
   end

   assign in_a_tready    = w_a_ready;
   assign in_b_tready    = w_b_ready;
   assign out_tdata      = r_out_tdata;
   assign out_tlast      = r_out_tlast;
   assign out_tvalid     = r_out_tvalid;
   assign mismatch_pulse = r_mismatch_pulse;
   assign mismatch_count = r_mismatch_count;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_addsub_input_sync.sv
// -----------------------------------------------------------------------------
// tb_addsub_input_sync
// Directed bench for addsub_input_sync. Packets are described by length and
// base value; the model pairs packet i of A with packet i of B, emits
// min(len_a, len_b) beats with tlast on the final one, and counts a mismatch
// (saturating) whenever the lengths differ.
// -----------------------------------------------------------------------------
module tb_addsub_input_sync;
   import addsub_pkg::*;

   localparam int ITEM_W  = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  clear = 1'b0;
   logic [ITEM_W-1:0]     in_a_tdata = '0;
   logic                  in_a_tlast = 1'b0;
   logic                  in_a_tvalid = 1'b0;
   logic                  in_a_tready;
   logic [ITEM_W-1:0]     in_b_tdata = '0;
   logic                  in_b_tlast = 1'b0;
   logic                  in_b_tvalid = 1'b0;
   logic                  in_b_tready;
   logic [2*ITEM_W-1:0]   out_tdata;
   logic                  out_tlast;
   logic                  out_tvalid;
   logic                  out_tready = 1'b1;
   logic                  mismatch_pulse;
   logic [CNT_W-1:0]      mismatch_count;
   logic [1:0]            dbg_state;

   addsub_input_sync #(.ITEM_W(ITEM_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .in_a_tdata     (in_a_tdata),
      .in_a_tlast     (in_a_tlast),
      .in_a_tvalid    (in_a_tvalid),
      .in_a_tready    (in_a_tready),
      .in_b_tdata     (in_b_tdata),
      .in_b_tlast     (in_b_tlast),
      .in_b_tvalid    (in_b_tvalid),
      .in_b_tready    (in_b_tready),
      .out_tdata      (out_tdata),
      .out_tlast      (out_tlast),
      .out_tvalid     (out_tvalid),
      .out_tready     (out_tready),
      .mismatch_pulse (mismatch_pulse),
      .mismatch_count (mismatch_count),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [2*ITEM_W:0]   exp_q[$];     // {tlast, B, A}
   logic [ITEM_W:0]     a_items[$];   // {tlast, data}
   logic [ITEM_W:0]     b_items[$];
   int                  mdl_count = 0;
   int                  mdl_pulses = 0;

   int                  pulse_seen = 0;
   int                  out_beats = 0;
   logic [2*ITEM_W:0]   last_seen = '0;
   int                  t_in_first = -1;
   int                  t_out_first = -1;
   int                  t_out_last = -1;
   bit                  prev_stall = 1'b0;
   logic [2*ITEM_W:0]   prev_beat = '0;

   bit                  rand_valid = 1'b0;
   bit                  rand_ready = 1'b0;
   bit                  ready_force = 1'b1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: one pair of packets, data counts up from a base value.
   task automatic add_pkt(input int la, input int lb, input logic [ITEM_W-1:0] a0,
                          input logic [ITEM_W-1:0] b0);
      int n;
      logic [ITEM_W-1:0] av, bv;
      n = (la < lb) ? la : lb;
      for (int i = 0; i < la; i++) begin
         av = a0 + ITEM_W'(i);
         a_items.push_back({(i == la - 1), av});
      end
      for (int i = 0; i < lb; i++) begin
         bv = b0 + ITEM_W'(i);
         b_items.push_back({(i == lb - 1), bv});
      end
      for (int i = 0; i < n; i++) begin
         av = a0 + ITEM_W'(i);
         bv = b0 + ITEM_W'(i);
         exp_q.push_back({(i == n - 1), bv, av});
      end
      if (la != lb) begin
         mdl_pulses++;
         if (mdl_count < CNT_MAX) mdl_count++;
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [2*ITEM_W:0] e;
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_beat", {out_tvalid, out_tlast, out_tdata}, {1'b1, prev_beat});
         end
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {out_tlast, out_tdata}, '1);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {out_tlast, out_tdata}, e);
            end
            last_seen = {out_tlast, out_tdata};
            out_beats++;
            t_out_last = cyc;
         end
         if (out_tvalid && t_out_first < 0) t_out_first = cyc;
         if (in_a_tvalid && in_a_tready && in_b_tvalid && in_b_tready && t_in_first < 0)
            t_in_first = cyc;
         if (mismatch_pulse) pulse_seen++;
         prev_stall = out_tvalid && !out_tready && !clear;
         prev_beat  = {out_tlast, out_tdata};
      end
   end

   // ---------------- downstream ready driver ----------------
   always @(posedge clk) begin
      #1;
      out_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // ---------------- input drivers ----------------
   task automatic drive_a();
      logic [ITEM_W:0] it;
      bit hs;
      int n;
      while (a_items.size() > 0) begin
         it = a_items.pop_front();
         if (rand_valid && $urandom_range(0, 1) == 1) begin
            in_a_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         in_a_tvalid = 1'b1;
         in_a_tlast  = it[ITEM_W];
         in_a_tdata  = it[ITEM_W-1:0];
         n = 0;
         forever begin
            @(negedge clk);
            hs = in_a_tready;
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 500) begin
               chk("a_handshake_timeout", n, 0);
               break;
            end
         end
      end
      in_a_tvalid = 1'b0;
   endtask

   task automatic drive_b();
      logic [ITEM_W:0] it;
      bit hs;
      int n;
      while (b_items.size() > 0) begin
         it = b_items.pop_front();
         if (rand_valid && $urandom_range(0, 1) == 1) begin
            in_b_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         in_b_tvalid = 1'b1;
         in_b_tlast  = it[ITEM_W];
         in_b_tdata  = it[ITEM_W-1:0];
         n = 0;
         forever begin
            @(negedge clk);
            hs = in_b_tready;
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 500) begin
               chk("b_handshake_timeout", n, 0);
               break;
            end
         end
      end
      in_b_tvalid = 1'b0;
   endtask

   task automatic run_traffic();
      int n;
      fork
         drive_a();
         drive_b();
      join
      n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int p0;
      int b0;
      int total;
      int len;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_tlast", out_tlast, 0);
      chk("rst_pulse", mismatch_pulse, 0);
      chk("rst_count", mismatch_count, 0);
      chk("rst_state", dbg_state, S_PAIR);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // equal 8-beat packets
      t_in_first = -1; t_out_first = -1; t_out_last = -1;
      add_pkt(8, 8, 1, 100);
      run_traffic();
      chk("eq8_last_beat", last_seen, {1'b1, 32'd107, 32'd8});
      chk("eq8_latency", t_out_first - t_in_first, 1);
      chk("eq8_throughput", t_out_last - t_out_first, 7);
      chk("eq8_count", mismatch_count, 0);
      chk("eq8_pulses", pulse_seen, 0);

      // A shorter than B, then an equal packet
      p0 = pulse_seen;
      add_pkt(4, 6, 11, 200);
      add_pkt(3, 3, 21, 300);
      run_traffic();
      chk("a_short_count", mismatch_count, 1);
      chk("a_short_pulses", pulse_seen - p0, 1);
      chk("a_short_next_pkt", last_seen, {1'b1, 32'd302, 32'd23});

      // B shorter than A, then an equal packet
      p0 = pulse_seen;
      add_pkt(5, 3, 31, 400);
      add_pkt(2, 2, 41, 500);
      run_traffic();
      chk("b_short_count", mismatch_count, 2);
      chk("b_short_pulses", pulse_seen - p0, 1);
      chk("b_short_state", dbg_state, S_PAIR);

      // random valid / ready over ~1000 beats of equal packets
      rand_valid = 1'b1;
      rand_ready = 1'b1;
      p0 = out_beats;
      total = 0;
      while (total < 1000) begin
         len = $urandom_range(1, 16);
         b0  = $urandom;
         add_pkt(len, len, $urandom, b0);
         total += len;
      end
      run_traffic();
      rand_valid = 1'b0;
      rand_ready = 1'b0;
      ready_force = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("rand_beats", out_beats - p0, total);
      chk("rand_count", mismatch_count, mdl_count);

      // clear with a stalled output beat
      ready_force = 1'b0;
      @(posedge clk); #1;
      in_a_tvalid = 1'b1; in_a_tdata = 32'd7; in_a_tlast = 1'b0;
      in_b_tvalid = 1'b1; in_b_tdata = 32'd8; in_b_tlast = 1'b0;
      @(posedge clk); #1;
      in_a_tdata = 32'd9;
      in_b_tdata = 32'd10;
      clear = 1'b1;
      @(negedge clk);
      chk("clear_pre_tvalid", out_tvalid, 1);
      chk("clear_readies", {in_a_tready, in_b_tready}, 2'b00);
      @(posedge clk); #1;
      clear = 1'b0;
      in_a_tvalid = 1'b0;
      in_b_tvalid = 1'b0;
      mdl_count = 0;
      @(negedge clk);
      chk("clear_tvalid", out_tvalid, 0);
      chk("clear_count", mismatch_count, 0);
      chk("clear_state", dbg_state, S_PAIR);
      @(posedge clk); #1;
      ready_force = 1'b1;
      @(posedge clk); #1;
      add_pkt(2, 2, 61, 600);
      run_traffic();
      chk("post_clear_beat", last_seen, {1'b1, 32'd601, 32'd62});

      // saturation: 2^CNT_W + 3 mismatches
      p0 = pulse_seen;
      for (int i = 0; i < 19; i++) add_pkt(1, 2, 1000 + 10 * i, 2000 + 10 * i);
      run_traffic();
      chk("sat_count", mismatch_count, 15);
      chk("sat_model_count", mismatch_count, mdl_count);
      chk("sat_pulses", pulse_seen - p0, 19);
      chk("total_pulses", pulse_seen, mdl_pulses);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
